// File: rtl/enable_pulse_gen.sv
// Free-running modulo-2^BIT_SIZE counter with a one-cycle enable strobe at count zero.
// Serves as a tick source for slower logic in the same clock domain.
module enable_pulse_gen #(
    parameter int BIT_SIZE = 3
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_sclr,
    output logic                o_en,
    output logic [BIT_SIZE-1:0] o_cnt
);

    logic [BIT_SIZE-1:0] r_cnt;
    logic [BIT_SIZE-1:0] w_cnt_next;

    // Clear wins over increment; the increment wraps naturally at 2^BIT_SIZE.
    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if (i_sclr) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Decoded straight from the register, so the strobe has no extra latency.
    assign o_en  = (r_cnt == '0);
    assign o_cnt = r_cnt;

endmodule

// File: tb/tb_enable_pulse_gen.sv
// Directed bench for enable_pulse_gen at BIT_SIZE = 1, 3 and 4.
// All three instances share clock, reset and clear; each task checks the width it targets.
module tb_enable_pulse_gen;

    logic       clk;
    logic       rst_n;
    logic       sclr;
    logic       en1;
    logic [0:0] cnt1;
    logic       en3;
    logic [2:0] cnt3;
    logic       en4;
    logic [3:0] cnt4;

    int errors;
    int checks;

    enable_pulse_gen #(.BIT_SIZE(1)) dut1 (
        .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .o_en(en1), .o_cnt(cnt1)
    );
    enable_pulse_gen #(.BIT_SIZE(3)) dut3 (
        .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .o_en(en3), .o_cnt(cnt3)
    );
    enable_pulse_gen #(.BIT_SIZE(4)) dut4 (
        .clk(clk), .i_rst_n(rst_n), .i_sclr(sclr), .o_en(en4), .o_cnt(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sclr  = 1'b0;
        #2;
        checks++;
        if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_initial: cnt=%0d en=%0b, required cnt=0 en=1", cnt3, en3);
        end
        tick();
        checks++;
        if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: cnt=%0d en=%0b, required cnt=0 en=1", cnt3, en3);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (cnt3 !== 3'd1 || en3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: cnt=%0d en=%0b, required cnt=1 en=0", cnt3, en3);
        end
        tick();
        checks++;
        if (cnt3 !== 3'd2) begin
            errors++;
            $display("FAIL reset_count2: cnt=%0d, required 2", cnt3);
        end
        // Pull reset mid-cycle: the counter must clear with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_async: cnt=%0d en=%0b, required cnt=0 en=1", cnt3, en3);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (cnt3 !== 3'd1 || en3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_rerelease: cnt=%0d en=%0b, required cnt=1 en=0", cnt3, en3);
        end
        $display("test_reset done");
    endtask

    task automatic test_period();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        checks++;
        if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
            errors++;
            $display("FAIL period_clear: cnt=%0d en=%0b, required cnt=0 en=1", cnt3, en3);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (cnt3 !== 3'(k) || en3 !== 1'b0) begin
                errors++;
                $display("FAIL period_count%0d: cnt=%0d en=%0b, required cnt=%0d en=0", k, cnt3, en3, k);
            end
        end
        tick();
        checks++;
        if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
            errors++;
            $display("FAIL period_wrap: cnt=%0d en=%0b, required cnt=0 en=1", cnt3, en3);
        end
        for (int k = 1; k <= 2; k++) begin
            tick();
            checks++;
            if (cnt3 !== 3'(k) || en3 !== 1'b0) begin
                errors++;
                $display("FAIL period_after_wrap%0d: cnt=%0d en=%0b, required cnt=%0d en=0", k, cnt3, en3, k);
            end
        end
        $display("test_period done");
    endtask

    task automatic test_mid_clear();
        // Counter is at 2 on entry; three edges bring it to 5.
        tick();
        tick();
        tick();
        checks++;
        if (cnt3 !== 3'd5) begin
            errors++;
            $display("FAIL mid_reach5: cnt=%0d, required 5", cnt3);
        end
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        checks++;
        if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear: cnt=%0d en=%0b, required cnt=0 en=1", cnt3, en3);
        end
        for (int k = 1; k <= 7; k++) begin
            tick();
            checks++;
            if (en3 !== 1'b0) begin
                errors++;
                $display("FAIL mid_gap%0d: en=%0b, required 0", k, en3);
            end
        end
        tick();
        checks++;
        if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
            errors++;
            $display("FAIL mid_next_pulse: cnt=%0d en=%0b, required cnt=0 en=1", cnt3, en3);
        end
        $display("test_mid_clear done");
    endtask

    task automatic test_held_clear();
        tick();
        tick();
        sclr = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
                errors++;
                $display("FAIL held_edge%0d: cnt=%0d en=%0b, required cnt=0 en=1", k, cnt3, en3);
            end
        end
        sclr = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (cnt3 !== 3'(k) || en3 !== 1'b0) begin
                errors++;
                $display("FAIL held_resume%0d: cnt=%0d en=%0b, required cnt=%0d en=0", k, cnt3, en3, k);
            end
        end
        $display("test_held_clear done");
    endtask

    task automatic test_sclr_at_max();
        // Counter at 3 on entry; four edges reach 7, then clear on the wrap edge.
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (cnt3 !== 3'd7) begin
            errors++;
            $display("FAIL max_reach7: cnt=%0d, required 7", cnt3);
        end
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        checks++;
        if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
            errors++;
            $display("FAIL max_clear: cnt=%0d en=%0b, required cnt=0 en=1", cnt3, en3);
        end
        $display("test_sclr_at_max done");
    endtask

    task automatic test_async_mid();
        for (int k = 0; k < 6; k++) tick();
        checks++;
        if (cnt3 !== 3'd6) begin
            errors++;
            $display("FAIL async_reach6: cnt=%0d, required 6", cnt3);
        end
        #2;
        rst_n = 1'b0;
        sclr  = 1'b1;
        #1;
        checks++;
        if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
            errors++;
            $display("FAIL async_immediate: cnt=%0d en=%0b, required cnt=0 en=1", cnt3, en3);
        end
        tick();
        checks++;
        if (cnt3 !== 3'd0 || en3 !== 1'b1) begin
            errors++;
            $display("FAIL async_over_sclr: cnt=%0d en=%0b, required cnt=0 en=1", cnt3, en3);
        end
        rst_n = 1'b1;
        tick();
        sclr = 1'b0;
        checks++;
        if (cnt3 !== 3'd0) begin
            errors++;
            $display("FAIL async_sclr_after: cnt=%0d, required 0", cnt3);
        end
        tick();
        checks++;
        if (cnt3 !== 3'd1 || en3 !== 1'b0) begin
            errors++;
            $display("FAIL async_resume: cnt=%0d en=%0b, required cnt=1 en=0", cnt3, en3);
        end
        $display("test_async_mid done");
    endtask

    task automatic test_bit1();
        logic exp_en;
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        exp_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (en1 !== exp_en || cnt1 !== ~exp_en) begin
                errors++;
                $display("FAIL bit1_cycle%0d: en=%0b cnt=%0d, required en=%0b", k, en1, cnt1, exp_en);
            end
            exp_en = ~exp_en;
            tick();
        end
        $display("test_bit1 done");
    endtask

    task automatic test_bit4();
        int pulses;
        pulses = 0;
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        for (int k = 0; k < 48; k++) begin
            if (en4 === 1'b1) pulses++;
            checks++;
            if (cnt4 !== 4'(k % 16) || en4 !== (k % 16 == 0)) begin
                errors++;
                $display("FAIL bit4_cycle%0d: cnt=%0d en=%0b, required cnt=%0d en=%0b",
                         k, cnt4, en4, k % 16, (k % 16 == 0));
            end
            tick();
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL bit4_pulse_count: got %0d, required 3", pulses);
        end
        $display("test_bit4 done");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        sclr   = 1'b0;
        test_reset();
        test_period();
        test_mid_clear();
        test_held_clear();
        test_sclr_at_max();
        test_async_mid();
        test_bit1();
        test_bit4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/enable_pulse_gen.md
Name: enable_pulse_gen

Overview:
- Free-running modulo-2^BIT_SIZE cycle counter.
- Emits a single-cycle enable strobe (o_en) once per counter period, whenever the count is zero.
- Used as a clock-enable / tick source for slower logic in the same clock domain.
- Provides a synchronous clear for phase alignment and an asynchronous active-low reset.

Parameters:
- BIT_SIZE, default 3, width of the internal counter.
  - Strobe period = 2^BIT_SIZE clk cycles.
  - Legal range 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset; forces counter to 0 immediately.
- i_sclr  input  1  synchronous clear, active-high; sampled on rising clk edge.
- o_en  output  1  enable strobe; high exactly when the counter equals 0.
- o_cnt  output  BIT_SIZE  current counter value, for debug and phase observation.

Behaviour:
- Reset is asynchronous and active-low; one clock.
- State: unsigned counter cnt[BIT_SIZE-1:0]; o_cnt = cnt.
- i_rst_n low:
  - cnt = 0 asynchronously, without waiting for a clock edge.
  - Held at 0 while i_rst_n stays low.
  - o_en = 1 during reset.
- Reset release: the first rising edge with i_rst_n high and i_sclr low advances cnt to 1.
- Rising clk edge with i_rst_n high, priority order:
  1. i_sclr = 1 -> cnt <= 0.
  2. otherwise -> cnt <= cnt + 1, modulo 2^BIT_SIZE (2^BIT_SIZE - 1 wraps to 0, no saturation).
- o_en = (cnt == 0):
  - Decoded combinationally from the registered counter, so it is glitch-free relative to clk.
  - Zero additional latency: o_en is valid in the same cycle cnt becomes 0.
- Steady state:
  - o_en is high for exactly 1 cycle out of every 2^BIT_SIZE.
  - Each high cycle is followed by 2^BIT_SIZE - 1 low cycles.
- Clear timing: after the edge where i_sclr = 1 is sampled, o_en = 1 in the following cycle.
- i_sclr held high for N edges: cnt stays 0 and o_en stays high for that whole span.
- i_sclr asserted mid-count: period restarts from 0 at that edge; the remaining count is discarded.
- i_sclr while cnt = 2^BIT_SIZE - 1: result is 0, same as a natural wrap.
- i_rst_n low has priority over i_sclr and clk at all times.
- BIT_SIZE = 1: o_en toggles every cycle (1,0,1,0...).
- No X-propagation dependence: the counter is defined after reset or after the first sampled i_sclr.

Test Plan:
- Reset: BIT_SIZE=3, drive i_rst_n=0 mid-cycle -> o_cnt=0 and o_en=1 immediately, before the next clk edge. Release with i_sclr=0 -> next edge o_cnt=1, o_en=0.
- Sync clear and period: i_sclr=1 for one edge, then 0 -> o_en=1 (cnt 0). Next edge o_en=0 (cnt 1). o_en stays 0 for counts 1..7. Edge 8 after clear: o_en=1 (wrap to 0). Next two edges: o_en=0.
- Mid-count clear: let cnt reach 5, assert i_sclr for one edge -> cnt=0, o_en=1. Next pulse exactly 8 edges later.
- Held clear: i_sclr=1 for 4 consecutive edges -> o_en=1 and o_cnt=0 throughout. On release, the counter resumes 1,2,...
- Async reset mid-count: cnt=6, pull i_rst_n low between edges -> o_cnt=0 at once, no clk edge needed. Reset has priority over a simultaneous i_sclr=1.
- Parameter sweep: BIT_SIZE=1 -> o_en alternates 1,0 each cycle. BIT_SIZE=4 -> one pulse per 16 cycles over 3 periods.
